// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Far-end responder for the M-stage data-memory interface. Models a
//   word-addressed RAM that takes LATENCY internal cycles per access. It
//   holds the pipeline with mem_stall until the access completes.
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous, active-high reset
//   req_valid   M stage holds a load or store
//   MemWriteM   1 = store, 0 = load (qualified by req_valid)
//   ALUResultM  byte address; word index = ALUResultM[log2(DEPTH)+1:2]
//   WriteDataM  store data
//   byteEnable  lane enables, bit i covers bits [8i+7:8i]
//   ReadDataM   load data; valid in DONE, held until the next load completes
//   mem_stall   high while an access is in progress
//   mem_err     one-cycle pulse in DONE when an access was rejected
//   dbg_state   current FSM state (IDLE=0, BUSY=1, DONE=2)
//
// Handshake: the datapath raises req_valid and keeps its request stable
// while mem_stall is high. The request is captured on the IDLE edge where
// req_valid is seen. mem_stall then stays high for LATENCY+1 cycles. It
// drops in DONE, where the datapath advances, and the responder ignores
// req_valid for that one cycle. Any later change to the inputs has no effect
// on the access in flight.
module data_mem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        MemWriteM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [3:0]  byteEnable,
  output logic [31:0] ReadDataM,
  output logic        mem_stall,
  output logic        mem_err,
  output logic [1:0]  dbg_state
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [31:0]   ADDR_LIMIT = 32'(4 * DEPTH);
  localparam logic [CW-1:0] CNT_INIT   = CW'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          access;

  // Latched request
  logic [AW-1:0] req_idx;
  logic          req_we;
  logic [31:0]   req_data;
  logic [3:0]    req_be;
  logic          req_reject;

  logic [31:0] mem [DEPTH];
  logic [31:0] lane_mask;
  logic        reject_in;

  // The full-width compare covers every address bit above the word index.
  // An empty lane mask is also rejected, so it cannot act as a silent no-op.
  assign reject_in = (ALUResultM >= ADDR_LIMIT) || (byteEnable == 4'b0000);
  assign lane_mask = {{8{req_be[3]}}, {8{req_be[2]}}, {8{req_be[1]}}, {8{req_be[0]}}};
  assign dbg_state = state;

  always_comb begin
    state_nxt = state;
    mem_stall = 1'b0;
    accept    = 1'b0;
    access    = 1'b0;
    case (state)
      IDLE: begin
        mem_stall = req_valid;
        if (req_valid) begin
          accept    = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        mem_stall = 1'b1;
        if (cnt == '0) begin
          access    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        // The datapath advances on this edge. req_valid still belongs to the
        // completed request.
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Keep the pipeline free while reset is held, even if req_valid is high.
    if (reset) mem_stall = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      ReadDataM  <= '0;
      mem_err    <= 1'b0;
      req_idx    <= '0;
      req_we     <= 1'b0;
      req_data   <= '0;
      req_be     <= '0;
      req_reject <= 1'b0;
    end else begin
      state   <= state_nxt;
      mem_err <= access && req_reject;
      if (accept) begin
        req_idx    <= ALUResultM[AW+1:2];
        req_we     <= MemWriteM;
        req_data   <= WriteDataM;
        req_be     <= byteEnable;
        req_reject <= reject_in;
        cnt        <= CNT_INIT;
      end else if (state == BUSY && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (access && !req_we) begin
        ReadDataM <= req_reject ? 32'h0 : (mem[req_idx] & lane_mask);
      end
    end
  end

  // The RAM has no reset. access is low whenever the FSM is held in IDLE by
  // reset, so an abandoned store never reaches the array.
  always_ff @(posedge clk) begin
    if (access && req_we && !req_reject) begin
      for (int i = 0; i < 4; i++) begin
        if (req_be[i]) mem[req_idx][8*i +: 8] <= req_data[8*i +: 8];
      end
    end
  end

endmodule
